// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential {exponent, fraction} float multiplier with shift-add mantissa product.
// Latency: out_valid rises MAN_W+3 cycles after the accepting edge, zero operands included.
// Backpressure: result, ovf and unf are held in DONE until out_ready; in_ready is high only in IDLE.
//
// Ports: clk, rst (synchronous, active-high); in_valid/in_ready with operands flp_a, flp_b;
//        out_valid/out_ready with result, ovf (saturated), unf (flushed to zero).
// Build option: define FPM_ROUND_EN for round-to-nearest-even; otherwise truncation.
module fp_mul_seq #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W-1:0] flp_a,
    input  logic [EXP_W+MAN_W-1:0] flp_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W-1:0] result,
    output logic                   ovf,
    output logic                   unf
);
    localparam int W     = EXP_W + MAN_W;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int PW    = 2 * (MAN_W + 1);
    localparam int CNT_W = $clog2(MAN_W + 2);
    // One extra bit over the exponent-sum width so a rounding carry on the
    // largest sum cannot wrap into the sign bit.
    localparam int EW    = EXP_W + 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAN_W + 1);
    localparam logic [EW-1:0]    EXP_MAX  = EW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

    state_t             r_state;
    logic [MAN_W:0]     r_mant_a;
    logic [MAN_W:0]     r_mant_b;
    logic [EXP_W+1:0]   r_esum;
    logic               r_zero;
    logic [PW-1:0]      r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [W-1:0]       r_result;
    logic               r_ovf;
    logic               r_unf;

    logic [PW-1:0]      w_addend;
    logic               w_msb;
    logic [MAN_W-1:0]   w_mant_t;
    logic [EW-1:0]      w_exp_base;
    logic [MAN_W-1:0]   w_mant;
    logic [EW-1:0]      w_exp;
    logic               w_unf;
    logic               w_ovf;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign ovf       = r_ovf;
    assign unf       = r_unf;

    assign w_addend = {{(MAN_W+1){1'b0}}, r_mant_a} << r_cnt;

    // Product of two 1.x mantissas lies in [1,4): either the top bit is set
    // (value >= 2, shift right by one more) or the next bit is.
    assign w_msb      = r_acc[PW-1];
    assign w_mant_t   = w_msb ? r_acc[2*MAN_W:MAN_W+1] : r_acc[2*MAN_W-1:MAN_W];
    assign w_exp_base = {1'b0, r_esum} - EW'(BIAS) + {{(EW-1){1'b0}}, w_msb};

`ifdef FPM_ROUND_EN
    logic             w_guard;
    logic             w_sticky;
    logic             w_round_up;
    logic [MAN_W:0]   w_mant_r;

    assign w_guard    = w_msb ? r_acc[MAN_W] : r_acc[MAN_W-1];
    assign w_sticky   = w_msb ? (|r_acc[MAN_W-1:0]) : (|r_acc[MAN_W-2:0]);
    assign w_round_up = w_guard & (w_sticky | w_mant_t[0]);
    assign w_mant_r   = {1'b0, w_mant_t} + {{MAN_W{1'b0}}, w_round_up};
    // A carry out leaves the fraction all-zero and bumps the exponent before
    // the range checks.
    assign w_mant     = w_mant_r[MAN_W-1:0];
    assign w_exp      = w_exp_base + {{(EW-1){1'b0}}, w_mant_r[MAN_W]};
`else
    // Low product bits only matter for rounding; truncation drops them.
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^r_acc[MAN_W-1:0];
    assign w_mant        = w_mant_t;
    assign w_exp         = w_exp_base;
`endif

    // w_exp is two's complement: negative or zero is underflow.
    assign w_unf = w_exp[EW-1] | (w_exp == '0);
    assign w_ovf = ~w_exp[EW-1] & (w_exp > EXP_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mant_a    <= '0;
            r_mant_b    <= '0;
            r_esum      <= '0;
            r_zero      <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mant_a   <= {1'b1, flp_a[MAN_W-1:0]};
                        r_mant_b   <= {1'b1, flp_b[MAN_W-1:0]};
                        r_esum     <= (EXP_W+2)'(flp_a[W-1:MAN_W]) + (EXP_W+2)'(flp_b[W-1:MAN_W]);
                        r_zero     <= ~(|flp_a[W-1:MAN_W]) | ~(|flp_b[W-1:MAN_W]);
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_MUL;
                    end
                end
                S_MUL: begin
                    // Counter walks bits 0..MAN_W; the cycle it reads MAN_W+1 hands off.
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_NORM;
                    end else begin
                        if (r_mant_b[r_cnt]) begin
                            r_acc <= r_acc + w_addend;
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_NORM: begin
                    if (r_zero) begin
                        r_result <= '0;
                        r_ovf    <= 1'b0;
                        r_unf    <= 1'b0;
                    end else if (w_unf) begin
                        r_result <= '0;
                        r_ovf    <= 1'b0;
                        r_unf    <= 1'b1;
                    end else if (w_ovf) begin
                        r_result <= '1;
                        r_ovf    <= 1'b1;
                        r_unf    <= 1'b0;
                    end else begin
                        r_result <= {w_exp[EXP_W-1:0], w_mant};
                        r_ovf    <= 1'b0;
                        r_unf    <= 1'b0;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_result    <= '0;
                        r_ovf       <= 1'b0;
                        r_unf       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: scoreboard bench for fp_mul_seq with directed corner cases and random operands.
// Latency: expects out_valid 13 cycles after each accepting edge.
// Backpressure: random and held-low out_ready phases; outputs must stay stable while stalled.
module tb_fp_mul_seq;
    localparam int EXP_W = 6;
    localparam int MAN_W = 10;
    localparam int W     = EXP_W + MAN_W;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int LAT   = MAN_W + 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] flp_a;
    logic [W-1:0] flp_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         ovf;
    logic         unf;

    fp_mul_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .flp_a(flp_a), .flp_b(flp_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         o;
        logic         u;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   rand_rdy = 1'b0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Reference: exact integer product, then pick the exponent and trim the
    // mantissa from the numeric value itself.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   r;
        int     ea, eb, sh, e;
        longint ma, mb, p, m, rem;
        ea = int'(a[W-1:MAN_W]);
        eb = int'(b[W-1:MAN_W]);
        ma = (longint'(1) << MAN_W) + longint'(a[MAN_W-1:0]);
        mb = (longint'(1) << MAN_W) + longint'(b[MAN_W-1:0]);
        p  = ma * mb;
        sh = (p >= (longint'(1) << (2*MAN_W+1))) ? MAN_W + 1 : MAN_W;
        m  = p >> sh;
        rem = p - (m << sh);
        e  = ea + eb - BIAS + (sh - MAN_W);
`ifdef FPM_ROUND_EN
        if (rem > (longint'(1) << (sh-1)) || (rem == (longint'(1) << (sh-1)) && (m % 2 == 1))) m++;
        if (m == (longint'(1) << (MAN_W+1))) begin
            m = longint'(1) << MAN_W;
            e++;
        end
`else
        if (rem < 0) m = 0;
`endif
        r.acc = 0;
        r.o = 1'b0;
        r.u = 1'b0;
        if (ea == 0 || eb == 0) r.res = '0;
        else if (e < 1) begin r.res = '0; r.u = 1'b1; end
        else if (e > (1 << EXP_W) - 1) begin r.res = '1; r.o = 1'b1; end
        else r.res = W'((longint'(e) << MAN_W) | (m & ((longint'(1) << MAN_W) - 1)));
        return r;
    endfunction

    // Monitor: compare at the first cycle of each result, check flag invariants every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("flag_invariant", {30'd0, ovf, unf},
                (!out_valid || (ovf && unf)) ? 32'd0 : {30'd0, ovf, unf});
            if (out_valid && !prev_v) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = q.pop_front();
                    chk("result", 32'(result), 32'(e.res));
                    chk("ovf", 32'(ovf), 32'(e.o));
                    chk("unf", 32'(unf), 32'(e.u));
                    chk("latency", 32'(cyc - e.acc), 32'(LAT));
                end
            end
        end
        prev_v = out_valid;
    end

    initial forever begin
        @(negedge clk);
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        int   n = 0;
        exp_t x;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now("in_ready_wait");
            return;
        end
        flp_a = a;
        flp_b = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        x = e;
        x.acc = cyc;
        q.push_back(x);
    endtask

    task automatic issue_c(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] r, input logic o, input logic u);
        exp_t e;
        e.res = r; e.o = o; e.u = u; e.acc = 0;
        issue(a, b, e);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || out_valid) fail_now("drain");
    endtask

    function automatic logic [W-1:0] rand_op();
        int k, ex;
        k = int'($urandom_range(0, 9));
        if (k == 0) ex = 0;
        else if (k == 1) ex = int'($urandom_range(1, 3));
        else if (k == 2) ex = int'($urandom_range(60, 63));
        else ex = int'($urandom_range(18, 44));
        return {EXP_W'(ex), MAN_W'($urandom)};
    endfunction

    initial begin
        int n;
        logic [W-1:0] a, b;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flp_a = '0; flp_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", {30'd0, ovf, unf}, 32'd0);
        rst = 1'b0;

        issue_c(16'h7C00, 16'h7C00, 16'h7C00, 1'b0, 1'b0);
        drain();
        issue_c(16'h7E00, 16'h7E00, 16'h8080, 1'b0, 1'b0);
`ifdef FPM_ROUND_EN
        issue_c(16'h7C01, 16'h7E00, 16'h7E02, 1'b0, 1'b0);
`else
        issue_c(16'h7C01, 16'h7E00, 16'h7E01, 1'b0, 1'b0);
`endif
        issue_c(16'hFC00, 16'h8000, 16'hFFFF, 1'b1, 1'b0);
        issue_c(16'h0400, 16'h0400, 16'h0000, 1'b0, 1'b1);
        issue_c(16'h0123, 16'h7C00, 16'h0000, 1'b0, 1'b0);
        drain();

        // Back-pressure: stall in DONE while poking in_valid.
        out_ready = 1'b0;
        issue_c(16'h7E00, 16'h7E00, 16'h8080, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("bp_wait_valid");
        for (int i = 0; i < 5; i++) begin
            flp_a = 16'hFC00;
            flp_b = 16'hFC00;
            in_valid = (i % 2 == 0);
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_result", 32'(result), 32'h8080);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        repeat (20) @(negedge clk);
        chk("bp_no_capture", 32'(q.size()), 32'd0);

        // Reset four cycles into an operation: nothing may come out of it.
        issue_c(16'hFC00, 16'h8000, 16'hFFFF, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        q.delete();
        issue_c(16'h7C00, 16'h7C00, 16'h7C00, 1'b0, 1'b0);
        drain();

        // Random operands with random consumer stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 120; i++) begin
            a = rand_op();
            b = rand_op();
            issue(a, b, model(a, b));
        end
        rand_rdy = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
